// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and sizing helpers for the serial adder
package serial_add_pkg;

    localparam int NUM_BYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index only ever reaches nbytes-1, so clog2(nbytes) bits suffice (min 1).
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/adder_8bit.sv
// rtl/adder_8bit.sv - single 8-bit adder slice with carry in and carry out
module adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'b0, cin_i};

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - byte-serial adder sequencing one shared 8-bit slice LSB first
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NUM_BYTES = NUM_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] op_a,
    input  logic [8*NUM_BYTES-1:0] op_b,
    input  logic                   carry_in,
    output logic                   busy,
    output logic                   done,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   overflow
);

    localparam int OW    = 8 * NUM_BYTES;
    localparam int IDX_W = idx_width(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [OW-1:0]    a_q;
    logic [OW-1:0]    b_q;
    logic             carry_q;
    logic [OW-1:0]    result_q;
    logic             overflow_q;

    logic [7:0]       slice_sum;
    logic             slice_cout;

    adder_8bit u_slice (
        .a_i    (a_q[{idx_q, 3'b000} +: 8]),
        .b_i    (b_q[{idx_q, 3'b000} +: 8]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // DONE accepts a new start exactly like IDLE so held start runs back-to-back.
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= carry_in;
                        idx_q   <= '0;
                        state_q <= ADD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ADD: begin
                    result_q[{idx_q, 3'b000} +: 8] <= slice_sum;
                    carry_q                        <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        overflow_q <= slice_cout;
                        idx_q      <= '0;
                        state_q    <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == ADD);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        carry_in = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_res;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[7];

    serial_add_ctrl #(.NUM_BYTES(4)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One isolated operation: inputs are scrambled right after accept to prove they are latched.
    task automatic run_op(input vec_t v);
        @(posedge clk); #1;
        op_a = v.a; op_b = v.b; carry_in = v.cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = ~v.a; op_b = ~v.b; carry_in = ~v.cin;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("busy_in_add", busy, 1);
            check("no_early_done", done, 0);
            @(posedge clk);
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        check("result", result, v.exp_res);
        check("overflow", overflow, v.exp_ov);
        @(posedge clk);
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        check("result_held", result, v.exp_res);
        check("overflow_held", overflow, v.exp_ov);
    endtask

    initial begin
        int          done_cnt;
        logic [31:0] a_cur;

        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0};
        vecs[1] = '{32'h00FF_00FF, 32'h0000_0001, 1'b1, 32'h00FF_0101, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Start pulses and operand churn during ADD must not disturb the latched operation.
        @(posedge clk); #1;
        op_a = 32'h1000_0001; op_b = 32'h2000_0002; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            start = ~start; op_a = $urandom; op_b = $urandom; carry_in = $urandom_range(0, 1);
            @(negedge clk);
            check("ign_busy", busy, 1);
            if (done) done_cnt++;
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                check("ign_result", result, 32'h3000_0003);
                check("ign_overflow", overflow, 0);
            end
            @(posedge clk);
        end
        check("ign_one_done", done_cnt, 1);
        @(negedge clk);
        check("ign_idle", busy, 0);

        // Reset during the second ADD cycle aborts with no done.
        @(posedge clk); #1;
        op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555; carry_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_overflow", overflow, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort_stays_idle", done_cnt, 0);
        run_op(vecs[3]);

        // Held start: done every 5 cycles, no idle gap between operations.
        @(posedge clk); #1;
        a_cur = 32'h0000_00FF;
        op_a = a_cur; op_b = 32'h0000_0001; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if ((k % 5) == 4) begin
                check("b2b_done", done, 1);
                check("b2b_busy_low", busy, 0);
                check("b2b_result", result, a_cur + 32'h1);
                a_cur = a_cur + 32'h0000_0100;
                op_a = a_cur;
                if (k == 14) start = 1'b0;
            end else begin
                check("b2b_busy", busy, 1);
                check("b2b_done_low", done, 0);
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("b2b_final_idle", busy, 0);
        check("b2b_final_nodone", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
